// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Holds the state enum, select codes, condition codes and per-state controls.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic       next_pc;
        logic       branch;
        logic       mem_w;
        logic       reg_w_mem;
        logic       alu_wb;
        logic       ir_write;
        logic       adr_src;
        logic       decode;
        logic       alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res_src;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        unique case (s)
            S_FETCH: begin
                c.next_pc  = 1'b1;
                c.ir_write = 1'b1;
                c.src_a    = SRCA_PC;
                c.src_b    = SRCB_FOUR;
                c.res_src  = RES_ALURES;
            end
            S_DECODE: begin
                c.decode  = 1'b1;
                c.src_a   = SRCA_PC;
                c.src_b   = SRCB_FOUR;
                c.res_src = RES_ALURES;
            end
            S_MEMADR: c.src_b = SRCB_IMM;
            S_MEMRD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.res_src   = RES_DATA;
                c.reg_w_mem = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            S_EXECR: c.alu_op = 1'b1;
            S_EXECI: begin
                c.alu_op = 1'b1;
                c.src_b  = SRCB_IMM;
            end
            S_ALUWB:  c.alu_wb = 1'b1;
            S_BRANCH: begin
                c.branch  = 1'b1;
                c.src_a   = SRCA_ALUOUT;
                c.src_b   = SRCB_IMM;
                c.res_src = RES_ALURES;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction/flags in, enables and selects out.
interface mc_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/mc_condlogic.sv
// NZCV flag register, condition evaluator, cond_ok latch and write gating.
module mc_condlogic
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       cond_latch,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       next_pc,
    input  logic       branch,
    input  logic       rd_is_pc,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_write
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ok_q, cond_ok_d;
    logic       cond_pass;
    logic       n, z, c, v;

    assign n = flags_q[FLAG_N];
    assign z = flags_q[FLAG_Z];
    assign c = flags_q[FLAG_C];
    assign v = flags_q[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        unique case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = n == v;
            COND_LT: cond_pass = n != v;
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // flag_w is only non-zero during EXECR/EXECI, so no state check here
    always_comb begin
        flags_d = flags_q;
        if (cond_ok_q && flag_w[1]) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (cond_ok_q && flag_w[0]) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
        cond_ok_d = cond_latch ? cond_pass : cond_ok_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            cond_ok_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    assign reg_write = reset && reg_w && cond_ok_q;
    assign mem_write = reset && mem_w && cond_ok_q;
    assign pc_write  = reset && (next_pc ||
                       (cond_ok_q && (branch || (reg_w && rd_is_pc))));

endmodule

// File: rtl/mc_controller.sv
// Moore FSM sequencing each instruction of the multicycle ARM core.
// Controls are registered per state; ALU decode is combinational on Instr.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    state_e     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [1:0] alu_ctl;
    logic [1:0] flag_w;
    logic       alu_reg_w;
    logic       is_arith;
    logic       is_cmp;
    logic       reg_w;
    logic       unused_instr;

    assign op    = bus.Instr[27:26];
    assign funct = bus.Instr[25:20];
    assign cmd   = funct[4:1];
    assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    op == OP_MEM:              state_d = S_MEMADR;
                    op == OP_DP && !funct[5]:  state_d = S_EXECR;
                    op == OP_DP && funct[5]:   state_d = S_EXECI;
                    op == OP_BR:               state_d = S_BRANCH;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
        ctrl_d = state_ctrl(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        alu_ctl   = ALU_ADD;
        alu_reg_w = 1'b0;
        is_arith  = 1'b0;
        is_cmp    = 1'b0;
        unique case (cmd)
            CMD_ADD: begin
                alu_reg_w = 1'b1;
                is_arith  = 1'b1;
            end
            CMD_SUB: begin
                alu_ctl   = ALU_SUB;
                alu_reg_w = 1'b1;
                is_arith  = 1'b1;
            end
            CMD_AND: begin
                alu_ctl   = ALU_AND;
                alu_reg_w = 1'b1;
            end
            CMD_ORR: begin
                alu_ctl   = ALU_ORR;
                alu_reg_w = 1'b1;
            end
            CMD_CMP: begin
                alu_ctl = ALU_SUB;
                is_cmp  = 1'b1;
            end
            default: alu_ctl = ALU_ADD;
        endcase
        flag_w = is_cmp ? 2'b11 : {funct[0], funct[0] && is_arith};
        if (!ctrl_q.alu_op) begin
            alu_ctl = ALU_ADD;
            flag_w  = 2'b00;
        end
    end

    // ALUWB writes back only for commands that produce a result
    assign reg_w = ctrl_q.reg_w_mem || (ctrl_q.alu_wb && alu_reg_w);

    mc_condlogic u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (bus.Instr[31:28]),
        .alu_flags  (bus.ALUFlags),
        .flag_w     (flag_w),
        .cond_latch (ctrl_q.decode),
        .reg_w      (reg_w),
        .mem_w      (ctrl_q.mem_w),
        .next_pc    (ctrl_q.next_pc),
        .branch     (ctrl_q.branch),
        .rd_is_pc   (bus.Instr[15:12] == 4'hF),
        .reg_write  (bus.RegWrite),
        .mem_write  (bus.MemWrite),
        .pc_write   (bus.PCWrite)
    );

    assign bus.IRWrite    = reset && ctrl_q.ir_write;
    assign bus.AdrSrc     = ctrl_q.adr_src;
    assign bus.ALUSrcA    = ctrl_q.src_a;
    assign bus.ALUSrcB    = ctrl_q.src_b;
    assign bus.ResultSrc  = ctrl_q.res_src;
    assign bus.ALUControl = alu_ctl;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle expected controls from a vector table.
module tb_mc_controller;

    typedef enum int {F, D, MA, MR, MB, MW, ER, EI, AW, BR} st_t;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] regsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [1:0] alu;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  flags;
        exp_t        exp;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    row_t rows[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic exp_t ex(st_t s, logic [31:0] ins, bit pcw,
                                bit memw, bit regw, logic [1:0] alu);
        exp_t e;
        e = '0;
        e.pcw    = pcw;
        e.memw   = memw;
        e.regw   = regw;
        e.alu    = alu;
        e.imm    = ins[27:26];
        e.regsrc = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
        case (s)
            F:  begin e.irw = 1; e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; end
            D:  begin e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; end
            MA: e.srcb = 2'b01;
            MR: e.adr = 1'b1;
            MB: e.res = 2'b01;
            MW: e.adr = 1'b1;
            EI: e.srcb = 2'b01;
            BR: begin e.srca = 2'b10; e.srcb = 2'b01; e.res = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t ex_rst(logic [31:0] ins);
        exp_t e;
        e = ex(F, ins, 0, 0, 0, 2'b00);
        e.irw = 1'b0;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t g;
        g.pcw    = bus.PCWrite;
        g.memw   = bus.MemWrite;
        g.regw   = bus.RegWrite;
        g.irw    = bus.IRWrite;
        g.adr    = bus.AdrSrc;
        g.regsrc = bus.RegSrc;
        g.srca   = bus.ALUSrcA;
        g.srcb   = bus.ALUSrcB;
        g.res    = bus.ResultSrc;
        g.imm    = bus.ImmSrc;
        g.alu    = bus.ALUControl;
        return g;
    endfunction

    task automatic check(string nm);
        exp_t g;
        exp_t e;
        g = sample();
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry, got %b", nm, g);
        end else begin
            e = sb.pop_front();
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %b want %b (pcw,memw,regw,irw,adr,regsrc,srca,srcb,res,imm,alu)",
                         nm, g, e);
            end
        end
    endtask

    task automatic add(string nm, logic [31:0] ins, logic [3:0] fl, st_t s,
                       bit pcw, bit memw, bit regw, logic [1:0] alu);
        row_t r;
        r.name  = {nm, ".", s.name()};
        r.instr = ins;
        r.flags = fl;
        r.exp   = ex(s, ins, pcw, memw, regw, alu);
        rows.push_back(r);
    endtask

    task automatic fd(string nm, logic [31:0] ins, logic [3:0] fl);
        add(nm, ins, fl, F, 1, 0, 0, 2'b00);
        add(nm, ins, fl, D, 0, 0, 0, 2'b00);
    endtask

    // Caller sits at posedge+1; each row is one cycle, checked at negedge
    task automatic run_rows();
        foreach (rows[i]) begin
            bus.Instr    = rows[i].instr;
            bus.ALUFlags = rows[i].flags;
            sb.push_back(rows[i].exp);
            @(negedge clk);
            check(rows[i].name);
            @(posedge clk);
            #1;
        end
        rows.delete();
    endtask

    initial begin
        bus.Instr    = 32'hE2821005;
        bus.ALUFlags = 4'b0000;
        reset        = 1'b0;

        repeat (3) begin
            @(negedge clk);
            sb.push_back(ex_rst(bus.Instr));
            check("reset_hold");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        fd("add_imm", 32'hE2821005, 4'b0100);
        add("add_imm", 32'hE2821005, 4'b0100, EI, 0, 0, 0, 2'b00);
        add("add_imm", 32'hE2821005, 4'b0100, AW, 0, 0, 1, 2'b00);
        fd("beq_z0", 32'h0A000002, 4'b0000);
        add("beq_z0", 32'h0A000002, 4'b0000, BR, 0, 0, 0, 2'b00);
        fd("cmp", 32'hE1510001, 4'b0100);
        add("cmp", 32'hE1510001, 4'b0100, ER, 0, 0, 0, 2'b01);
        add("cmp", 32'hE1510001, 4'b0100, AW, 0, 0, 0, 2'b00);
        fd("beq_z1", 32'h0A000002, 4'b0000);
        add("beq_z1", 32'h0A000002, 4'b0000, BR, 1, 0, 0, 2'b00);
        fd("bne_z1", 32'h1A000002, 4'b0000);
        add("bne_z1", 32'h1A000002, 4'b0000, BR, 0, 0, 0, 2'b00);
        fd("ldr", 32'hE5912004, 4'b0000);
        add("ldr", 32'hE5912004, 4'b0000, MA, 0, 0, 0, 2'b00);
        add("ldr", 32'hE5912004, 4'b0000, MR, 0, 0, 0, 2'b00);
        add("ldr", 32'hE5912004, 4'b0000, MB, 0, 0, 1, 2'b00);
        fd("str", 32'hE5812004, 4'b0000);
        add("str", 32'hE5812004, 4'b0000, MA, 0, 0, 0, 2'b00);
        add("str", 32'hE5812004, 4'b0000, MW, 0, 1, 0, 2'b00);
        fd("addsne", 32'h12921005, 4'b0000);
        add("addsne", 32'h12921005, 4'b0000, EI, 0, 0, 0, 2'b00);
        add("addsne", 32'h12921005, 4'b0000, AW, 0, 0, 0, 2'b00);
        fd("beq_kept", 32'h0A000002, 4'b0000);
        add("beq_kept", 32'h0A000002, 4'b0000, BR, 1, 0, 0, 2'b00);
        fd("addne", 32'h12821005, 4'b0000);
        add("addne", 32'h12821005, 4'b0000, EI, 0, 0, 0, 2'b00);
        add("addne", 32'h12821005, 4'b0000, AW, 0, 0, 0, 2'b00);
        fd("add_pc", 32'hE282F004, 4'b0000);
        add("add_pc", 32'hE282F004, 4'b0000, EI, 0, 0, 0, 2'b00);
        add("add_pc", 32'hE282F004, 4'b0000, AW, 1, 0, 1, 2'b00);
        fd("nop", 32'hEC000000, 4'b0000);
        fd("orr", 32'hE1821003, 4'b0000);
        add("orr", 32'hE1821003, 4'b0000, ER, 0, 0, 0, 2'b11);
        add("orr", 32'hE1821003, 4'b0000, AW, 0, 0, 1, 2'b00);
        fd("ands", 32'hE0121003, 4'b1011);
        add("ands", 32'hE0121003, 4'b1011, ER, 0, 0, 0, 2'b10);
        add("ands", 32'hE0121003, 4'b1011, AW, 0, 0, 1, 2'b00);
        fd("bmi", 32'h4A000002, 4'b0000);
        add("bmi", 32'h4A000002, 4'b0000, BR, 1, 0, 0, 2'b00);
        fd("bcs", 32'h2A000002, 4'b0000);
        add("bcs", 32'h2A000002, 4'b0000, BR, 0, 0, 0, 2'b00);
        fd("subs", 32'hE0521003, 4'b0011);
        add("subs", 32'hE0521003, 4'b0011, ER, 0, 0, 0, 2'b01);
        add("subs", 32'hE0521003, 4'b0011, AW, 0, 0, 1, 2'b00);
        fd("bvs", 32'h6A000002, 4'b0000);
        add("bvs", 32'h6A000002, 4'b0000, BR, 1, 0, 0, 2'b00);
        fd("blt", 32'hBA000002, 4'b0000);
        add("blt", 32'hBA000002, 4'b0000, BR, 1, 0, 0, 2'b00);
        fd("bhi", 32'h8A000002, 4'b0000);
        add("bhi", 32'h8A000002, 4'b0000, BR, 1, 0, 0, 2'b00);
        fd("bgt", 32'hCA000002, 4'b0000);
        add("bgt", 32'hCA000002, 4'b0000, BR, 0, 0, 0, 2'b00);
        fd("bnv", 32'hFA000002, 4'b0000);
        add("bnv", 32'hFA000002, 4'b0000, BR, 0, 0, 0, 2'b00);
        run_rows();

        // LDR aborted by reset in MEMRD
        fd("ldr_abort", 32'hE5912004, 4'b0000);
        add("ldr_abort", 32'hE5912004, 4'b0000, MA, 0, 0, 0, 2'b00);
        run_rows();
        sb.push_back(ex(MR, 32'hE5912004, 0, 0, 0, 2'b00));
        @(negedge clk);
        check("ldr_abort.MR");
        #2;
        reset = 1'b0;
        #1;
        sb.push_back(ex_rst(32'hE5912004));
        check("ldr_abort.rst_same_cycle");
        @(posedge clk);
        #1;
        sb.push_back(ex_rst(32'hE5912004));
        check("ldr_abort.rst_edge");
        reset = 1'b1;
        fd("ldr_after", 32'hE5912004, 4'b0000);
        add("ldr_after", 32'hE5912004, 4'b0000, MA, 0, 0, 0, 2'b00);
        run_rows();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
